nibble_bus_arbiter: RTL

Round-robin arbiter and sequencer that shares one 4-bit datapath between two requesters (A, B) by driving the select of the existing 4-bit 2:1 mux (`Mux_4bit_2i_1o`) and registering the mux output toward a single consumer. It sits between two register-file read ports and the accumulator input bus. Bursts are bounded in length, and A/B ownership alternates fairly under contention.

---
 rtl/nibble_bus_arbiter_pkg.sv | 17 +
 rtl/nibble_bus_arbiter_if.sv | 30 +++
 rtl/nibble_bus_arbiter_mux.sv | 13 +
 rtl/nibble_bus_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/nibble_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester nibble bus arbiter.
package nibble_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_A = 2'd1,
        ARB_GRANT_B = 2'd2
    } arb_state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    function automatic arb_state_e grant_state(input logic src);
        return (src == SRC_B) ? ARB_GRANT_B : ARB_GRANT_A;
    endfunction

endpackage

// File: rtl/nibble_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single consumer.
interface nibble_bus_arbiter_if #(
    parameter int W = 4
);
    // Every link is valid/ready: a beat moves on a rising edge where both are
    // high; valid never waits on ready, and a held beat keeps its data stable.
    logic         a_valid;
    logic [W-1:0] a_data;
    logic         a_ready;
    logic         b_valid;
    logic [W-1:0] b_data;
    logic         b_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_src;
    logic         out_ready;
    logic         sel;
    logic         busy;

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_src, sel, busy
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_src, sel, busy
    );

endinterface

// File: rtl/nibble_bus_arbiter_mux.sv
// Existing 2:1 nibble mux; s = 0 passes a, s = 1 passes b.
module Mux_4bit_2i_1o #(
    parameter int W = 4
) (
    input  logic         s,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r
);

    assign r = s ? b : a;

endmodule

// File: rtl/nibble_bus_arbiter.sv
// Round-robin burst arbiter steering the nibble mux between requesters A and B
// and registering the selected beat toward one consumer.
module nibble_bus_arbiter
    import nibble_bus_arbiter_pkg::*;
#(
    parameter int W     = 4,
    parameter int BURST = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    nibble_bus_arbiter_if.slave            bus,
    output arb_state_e                     state_o,
    output logic [$clog2(BURST+1)-1:0]     beat_cnt_o
);

    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    arb_state_e   state_q, state_d;
    logic         last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         sel_q;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         out_src_q, out_src_d;

    logic         gnt_src;
    logic         x_valid;
    logic         y_valid;
    logic         can_take;
    logic         accept;
    logic         burst_end;
    logic         a_rdy;
    logic         b_rdy;
    logic         pick;
    logic [W-1:0] mux_r;

    Mux_4bit_2i_1o #(.W(W)) u_mux (
        .s (sel_q),
        .a (bus.a_data),
        .b (bus.b_data),
        .r (mux_r)
    );

    assign gnt_src  = (state_q == ARB_GRANT_B) ? SRC_B : SRC_A;
    assign x_valid  = (gnt_src == SRC_B) ? bus.b_valid : bus.a_valid;
    assign y_valid  = (gnt_src == SRC_B) ? bus.a_valid : bus.b_valid;
    assign can_take = !out_valid_q || bus.out_ready;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        a_rdy       = 1'b0;
        b_rdy       = 1'b0;
        accept      = 1'b0;
        burst_end   = 1'b0;
        pick        = SRC_A;

        case (state_q)
            ARB_IDLE: begin
                if (bus.a_valid || bus.b_valid) begin
                    // On a tie the requester that did not own the bus last wins.
                    if (bus.a_valid && bus.b_valid) begin
                        pick = ~last_q;
                    end else begin
                        pick = bus.b_valid ? SRC_B : SRC_A;
                    end
                    state_d = grant_state(pick);
                    last_d  = pick;
                    cnt_d   = '0;
                end
            end
            ARB_GRANT_A, ARB_GRANT_B: begin
                a_rdy     = (gnt_src == SRC_A) && can_take;
                b_rdy     = (gnt_src == SRC_B) && can_take;
                accept    = x_valid && can_take;
                burst_end = accept && (cnt_q == CNT_LAST);
                if (accept) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (!x_valid || burst_end) begin
                    if (y_valid) begin
                        state_d = grant_state(~gnt_src);
                        last_d  = ~gnt_src;
                        cnt_d   = '0;
                    end else if (burst_end) begin
                        cnt_d = '0;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_r;
            out_src_d   = gnt_src;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            last_q      <= SRC_B;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC_A;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            sel_q       <= (state_d == ARB_GRANT_B);
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    // Readies are masked while reset is sampled so no beat is taken in that cycle.
    assign bus.a_ready   = a_rdy && !rst;
    assign bus.b_ready   = b_rdy && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q != ARB_IDLE) || out_valid_q;

    assign state_o    = state_q;
    assign beat_cnt_o = cnt_q;

endmodule
